// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file with post-reset clear sweep and optional write bypass
module register_file #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int BYPASS        = 1
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [ADDRESS_WIDTH-1:0] readRegister1,
  input  logic [ADDRESS_WIDTH-1:0] readRegister2,
  input  logic [ADDRESS_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0]    writeData,
  input  logic                     writeEnable,
  output logic [DATA_WIDTH-1:0]    readData1,
  output logic [DATA_WIDTH-1:0]    readData2,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LAST_INDEX = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {CLEARING, READY} state_t;

  state_t                  state, state_next;
  logic [ADDRESS_WIDTH:0]  clear_index, clear_index_next;
  logic [DATA_WIDTH-1:0]   entries [DEPTH];

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state       <= CLEARING;
      clear_index <= '0;
    end else begin
      state       <= state_next;
      clear_index <= clear_index_next;
    end
  end

  always_comb begin
    state_next       = state;
    clear_index_next = clear_index;
    if (state == CLEARING) begin
      clear_index_next = clear_index + 1'b1;
      if (clear_index == LAST_INDEX) state_next = READY;
    end
  end

  // The clear sweep owns the write port until every entry has been zeroed.
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (state == CLEARING)
        entries[clear_index[ADDRESS_WIDTH-1:0]] <= '0;
      else if (writeEnable && writeRegister != '0)
        entries[writeRegister] <= writeData;
    end
  end

  assign ready = (state == READY);

  always_comb begin
    readData1 = '0;
    if (state == READY && readRegister1 != '0) begin
      if (BYPASS != 0 && writeEnable && writeRegister == readRegister1)
        readData1 = writeData;
      else
        readData1 = entries[readRegister1];
    end
  end

  always_comb begin
    readData2 = '0;
    if (state == READY && readRegister2 != '0) begin
      if (BYPASS != 0 && writeEnable && writeRegister == readRegister2)
        readData2 = writeData;
      else
        readData2 = entries[readRegister2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file (bypass and non-bypass instances)
module tb_register_file;

  logic        clock;
  logic        resetN;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [31:0] readData1, readData2, nb_readData1, nb_readData2;
  logic        ready, nb_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .BYPASS(1)) dut (
    .clock(clock), .resetN(resetN),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .writeData(writeData), .writeEnable(writeEnable),
    .readData1(readData1), .readData2(readData2), .ready(ready)
  );

  register_file #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .BYPASS(0)) dut_nb (
    .clock(clock), .resetN(resetN),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .writeData(writeData), .writeEnable(writeEnable),
    .readData1(nb_readData1), .readData2(nb_readData2), .ready(nb_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic [31:0] e1, e2;
    logic [31:0] n1, n2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
    writeEnable = we; writeRegister = wa; writeData = wd;
    readRegister1 = r1; readRegister2 = r2;
  endtask

  // Advance one edge; the model only absorbs writes when the file is in service.
  task automatic tick(input bit model_live);
    @(posedge clock);
    if (model_live && writeEnable && writeRegister != 5'd0) model[writeRegister] = writeData;
    @(negedge clock);
  endtask

  function automatic logic [31:0] expect_read(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (byp && writeEnable && writeRegister == ra) return writeData;
    return model[ra];
  endfunction

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check({name, " byp rd1"}, readData1, 32'h0);
      check({name, " byp rd2"}, readData2, 32'h0);
      check({name, " nb rd1"}, nb_readData1, 32'h0);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 1; i <= 32; i++) begin
      tick(1'b0);
      check({name, " ready"}, {31'h0, ready}, {31'h0, (i == 32)});
      check({name, " nb ready"}, {31'h0, nb_ready}, {31'h0, (i == 32)});
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    case (ctrl)
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    logic [4:0]  wa;

    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd5, 32'h0,         5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h1234_5678, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd5, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd7, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 5'd9, 32'h0,         5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 5'd9, 32'h0,         5'd9, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    resetN = 1'b0;
    set_in(1'b1, 5'd4, 32'h0BAD_0BAD, 5'd4, 5'd4);
    @(negedge clock);
    tick(1'b0);
    tick(1'b0);
    check("reset ready", {31'h0, ready}, 32'h0);
    check("reset rd1", readData1, 32'h0);
    check("reset rd2", readData2, 32'h0);

    resetN = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    wait_ready("clear");
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    check_all_zero("post-clear");

    foreach (vecs[k]) begin
      set_in(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].r1, vecs[k].r2);
      #1;
      check($sformatf("vec%0d byp rd1", k), readData1, vecs[k].e1);
      check($sformatf("vec%0d byp rd2", k), readData2, vecs[k].e2);
      check($sformatf("vec%0d nb rd1", k), nb_readData1, vecs[k].n1);
      check($sformatf("vec%0d nb rd2", k), nb_readData2, vecs[k].n2);
      tick(1'b1);
    end

    set_in(1'b1, 5'd1, 32'd7, 5'd0, 5'd0); tick(1'b1);
    set_in(1'b1, 5'd2, 32'd5, 5'd0, 5'd0); tick(1'b1);
    set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd2); #1;
    res = alu(3'b010, readData1, readData2);
    check("alu add", res, 32'd12);
    set_in(1'b1, 5'd1, 32'd5, 5'd0, 5'd0); tick(1'b1);
    set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd2); #1;
    res = alu(3'b110, readData1, readData2);
    check("alu sub isZero", {31'h0, (res == 32'h0)}, 32'h1);

    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      set_in(1'($urandom), wa, $urandom,
             ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      #1;
      check("rand byp rd1", readData1, expect_read(1'b1, readRegister1));
      check("rand byp rd2", readData2, expect_read(1'b1, readRegister2));
      check("rand nb rd1", nb_readData1, expect_read(1'b0, readRegister1));
      check("rand nb rd2", nb_readData2, expect_read(1'b0, readRegister2));
      tick(1'b1);
    end

    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      tick(1'b1);
    end
    set_in(1'b0, 5'd0, 32'h0, 5'd31, 5'd3); #1;
    check("fill r31", readData1, 32'd31);
    check("fill r3", readData2, 32'd3);

    resetN = 1'b0; tick(1'b0);
    resetN = 1'b1;
    set_in(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3);
    for (int i = 0; i < 10; i++) tick(1'b0);
    #1;
    check("clearing rd1 forced", readData1, 32'h0);
    check("clearing ready", {31'h0, ready}, 32'h0);
    resetN = 1'b0; tick(1'b0);
    resetN = 1'b1;
    wait_ready("reclear");
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd3); #1;
    check("reclear r3", readData1, 32'h0);
    check_all_zero("reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
